// File: rtl/data_buffer_ring.sv
// data_buffer_ring: circular byte FIFO between the USB packet engines and the
// AHB-side data path. Each cycle it accepts one write of 1..WORD_BYTES bytes
// and one read of 1..WORD_BYTES bytes. Each side has a byte port and a word
// port. A transfer is either accepted whole or rejected whole.
//
// Ports:
//   clk, n_rst        clock (rising edge), asynchronous active-low reset
//   flush, clear      synchronous empty; flush also clears the error flags
//   buffer_occupancy  bytes stored (0..DEPTH)
//   full, empty       occupancy == DEPTH / occupancy == 0
//   overflow          sticky, set when a write is rejected
//   underflow         sticky, set when a read is rejected
//   store_byte/byte_in   push one byte (wins over store_word)
//   store_word/word_in   push the N low bytes of word_in, little-endian
//   get_byte/byte_out    pop one byte; byte_out shows the head byte
//   get_word/word_out    pop N bytes; word_out shows the next WORD_BYTES bytes
module data_buffer_ring #(
  parameter int DEPTH      = 64,
  parameter int WORD_BYTES = 4,
  parameter int OCC_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    flush,
  input  logic                    clear,
  output logic [OCC_W-1:0]        buffer_occupancy,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    store_byte,
  input  logic [7:0]              byte_in,
  input  logic [CNT_W-1:0]        store_word,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    get_byte,
  output logic [7:0]              byte_out,
  input  logic [CNT_W-1:0]        get_word,
  output logic [8*WORD_BYTES-1:0] word_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WB_C    = CNT_W'(WORD_BYTES);
  localparam logic [OCC_W:0]   DEPTH_C = (OCC_W + 1)'(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [CNT_W-1:0] wr_req_s;
  logic [CNT_W-1:0] rd_req_s;
  logic [CNT_W-1:0] wr_acc_s;
  logic [CNT_W-1:0] rd_acc_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             wr_en_s;
  logic             hold_s;
  logic [OCC_W:0]   space_s;
  logic [PTR_W-1:0] wr_idx_s  [WORD_BYTES];
  logic [PTR_W-1:0] rd_idx_s  [WORD_BYTES];
  logic [7:0]       wr_data_s [WORD_BYTES];

  // Request decode and all-or-nothing acceptance.
  // A same-cycle accepted read frees space for the write.
  always_comb begin
    hold_s = flush || clear;
    if (store_byte) begin
      wr_req_s = CNT_W'(1'b1);
    end else begin
      wr_req_s = store_word;
    end
    if (get_byte) begin
      rd_req_s = CNT_W'(1'b1);
    end else begin
      rd_req_s = get_word;
    end
    rd_ok_s  = (rd_req_s <= WB_C) && ((OCC_W + 1)'(rd_req_s) <= {1'b0, occ_r});
    rd_acc_s = rd_ok_s ? rd_req_s : '0;
    space_s  = DEPTH_C - {1'b0, occ_r} + (OCC_W + 1)'(rd_acc_s);
    wr_ok_s  = (wr_req_s <= WB_C) && ((OCC_W + 1)'(wr_req_s) <= space_s);
    wr_acc_s = wr_ok_s ? wr_req_s : '0;
    wr_en_s  = wr_ok_s && !hold_s;
  end

  // Per-lane memory addresses (wrapping modulo DEPTH) and write data.
  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      wr_idx_s[k] = wr_ptr_r + PTR_W'(k);
      rd_idx_s[k] = rd_ptr_r + PTR_W'(k);
      if (store_byte) begin
        wr_data_s[k] = byte_in;
      end else begin
        wr_data_s[k] = word_in[8*k +: 8];
      end
    end
  end

  // Storage array. It has no reset: unoccupied bytes are never shown.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (wr_en_s && (CNT_W'(k) < wr_acc_s)) begin
        mem_r[wr_idx_s[k]] <= wr_data_s[k];
      end
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (hold_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      if (flush) begin
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(wr_acc_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(rd_acc_s);
      occ_r    <= occ_r + OCC_W'(wr_acc_s) - OCC_W'(rd_acc_s);
      if (!wr_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (!rd_ok_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Read-side outputs come straight from registered state. Bytes that are
  // not occupied read as zero.
  always_comb begin
    word_out = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (OCC_W'(k) < occ_r) begin
        word_out[8*k +: 8] = mem_r[rd_idx_s[k]];
      end else begin
        word_out[8*k +: 8] = 8'h00;
      end
    end
    if (occ_r == '0) begin
      byte_out = 8'h00;
    end else begin
      byte_out = mem_r[rd_ptr_r];
    end
  end

  assign buffer_occupancy = occ_r;
  assign full             = (occ_r == OCC_W'(DEPTH));
  assign empty            = (occ_r == '0);
  assign overflow         = overflow_r;
  assign underflow        = underflow_r;

endmodule
